half_adder: RTL and testbench

// - Bit-parallel half adder: per lane, sum = a ^ b, carry = a & b.
// - Combinational outputs give same-cycle results; a registered copy with a valid flag feeds clocked consumers.
// - Leaf arithmetic block, used as the building block for full adders and ripple/carry-save chains.

---
 rtl/half_adder_pkg.sv | 30 +++
 rtl/half_adder_bit.sv | 38 +++
 rtl/half_adder.sv | 75 +++++++
 tb/tb_half_adder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/half_adder_pkg.sv
// Shared definitions for the half-adder building block: implementation
// selectors, the 2-bit per-lane result type and the reference lane equation.
package half_adder_pkg;

    // Implementation selectors for the IMPL_STYLE parameter.
    localparam int IMPL_DATAFLOW = 0;
    localparam int IMPL_CASE     = 1;

    // One lane's result. Packed as {carry, sum}, so the 2-bit value
    // always equals a + b for that lane.
    typedef struct packed {
        logic carry;
        logic sum;
    } lane_result_t;

    // Truth-table entries, indexed by the {a,b} input pair.
    localparam lane_result_t HA_RES_00 = '{carry: 1'b0, sum: 1'b0};
    localparam lane_result_t HA_RES_01 = '{carry: 1'b0, sum: 1'b1};
    localparam lane_result_t HA_RES_10 = '{carry: 1'b0, sum: 1'b1};
    localparam lane_result_t HA_RES_11 = '{carry: 1'b1, sum: 1'b0};

    // Dataflow form of a single lane.
    function automatic lane_result_t ha_eval(input logic a, input logic b);
        lane_result_t r;
        r.sum   = a ^ b;
        r.carry = a & b;
        return r;
    endfunction

endpackage

// File: rtl/half_adder_bit.sv
// Single half-adder lane. IMPL_STYLE picks between the dataflow equations and
// an explicit truth table; both give identical results for 0/1 inputs.
module half_adder_bit
    import half_adder_pkg::*;
#(
    parameter int IMPL_STYLE = IMPL_DATAFLOW
)
(
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    lane_result_t res;

    generate
        if (IMPL_STYLE == IMPL_CASE) begin : g_case
            // Truth-table lookup; an unknown input pair yields an unknown result
            // so X/Z stays confined to this lane.
            always_comb begin
                case ({a, b})
                    2'b00:   res = HA_RES_00;
                    2'b01:   res = HA_RES_01;
                    2'b10:   res = HA_RES_10;
                    2'b11:   res = HA_RES_11;
                    default: res = lane_result_t'(2'bxx);
                endcase
            end
        end else begin : g_dataflow
            assign res = ha_eval(a, b);
        end
    endgenerate

    assign sum   = res.sum;
    assign carry = res.carry;

endmodule

// File: rtl/half_adder.sv
// Bit-parallel half adder: WIDTH independent lanes with same-cycle
// combinational outputs plus a one-cycle registered copy qualified by a
// valid flag. Reset clears only the registered path.
module half_adder
    import half_adder_pkg::*;
#(
    parameter int WIDTH      = 1,
    parameter int IMPL_STYLE = IMPL_DATAFLOW
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry,
    output logic [WIDTH-1:0] sum_q,
    output logic [WIDTH-1:0] carry_q,
    output logic             out_valid
);

    logic [WIDTH-1:0] sum_comb;
    logic [WIDTH-1:0] carry_comb;

    logic [WIDTH-1:0] sum_reg;
    logic [WIDTH-1:0] sum_next;
    logic [WIDTH-1:0] carry_reg;
    logic [WIDTH-1:0] carry_next;
    logic             valid_reg;

    // One lane instance per bit; lanes never exchange carries.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
            half_adder_bit #(
                .IMPL_STYLE (IMPL_STYLE)
            ) u_bit (
                .a     (a[gi]),
                .b     (b[gi]),
                .sum   (sum_comb[gi]),
                .carry (carry_comb[gi])
            );
        end
    endgenerate

    // Capture a new result only when the inputs are qualified; otherwise hold.
    always_comb begin
        sum_next   = sum_reg;
        carry_next = carry_reg;
        if (in_valid) begin
            sum_next   = sum_comb;
            carry_next = carry_comb;
        end
    end

    // Output register stage; reset wins over in_valid and drops any in-flight result.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_reg   <= '0;
            carry_reg <= '0;
            valid_reg <= 1'b0;
        end else begin
            sum_reg   <= sum_next;
            carry_reg <= carry_next;
            valid_reg <= in_valid;
        end
    end

    assign sum       = sum_comb;
    assign carry     = carry_comb;
    assign sum_q     = sum_reg;
    assign carry_q   = carry_reg;
    assign out_valid = valid_reg;

endmodule

// File: tb/tb_half_adder.sv
// Directed and random checks of half_adder at WIDTH=1 and WIDTH=8, both
// implementation styles, combinational and registered paths.
module tb_half_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid;
    logic       a1, b1;
    logic [7:0] a8, b8;

    logic       s1d, c1d, sq1d, cq1d, ov1d;
    logic       s1c, c1c, sq1c, cq1c, ov1c;
    logic [7:0] s8d, c8d, sq8d, cq8d;
    logic       ov8d;
    logic [7:0] s8c, c8c, sq8c, cq8c;
    logic       ov8c;

    half_adder #(.WIDTH(1), .IMPL_STYLE(0)) u_w1_df (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(in_valid),
        .sum(s1d), .carry(c1d), .sum_q(sq1d), .carry_q(cq1d), .out_valid(ov1d)
    );
    half_adder #(.WIDTH(1), .IMPL_STYLE(1)) u_w1_cs (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(in_valid),
        .sum(s1c), .carry(c1c), .sum_q(sq1c), .carry_q(cq1c), .out_valid(ov1c)
    );
    half_adder #(.WIDTH(8), .IMPL_STYLE(0)) u_w8_df (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .in_valid(in_valid),
        .sum(s8d), .carry(c8d), .sum_q(sq8d), .carry_q(cq8d), .out_valid(ov8d)
    );
    half_adder #(.WIDTH(8), .IMPL_STYLE(1)) u_w8_cs (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .in_valid(in_valid),
        .sum(s8c), .carry(c8c), .sum_q(sq8c), .carry_q(cq8c), .out_valid(ov8c)
    );

    int pass_count  = 0;
    int total_count = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total_count++;
        assert (obs === exp) pass_count++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_comb1(input string step, input logic e_s, input logic e_c);
        check({step, " w1df sum"},   {7'b0, s1d}, {7'b0, e_s});
        check({step, " w1df carry"}, {7'b0, c1d}, {7'b0, e_c});
        check({step, " w1cs sum"},   {7'b0, s1c}, {7'b0, e_s});
        check({step, " w1cs carry"}, {7'b0, c1c}, {7'b0, e_c});
    endtask

    task automatic check_comb8(input string step, input logic [7:0] e_s, input logic [7:0] e_c);
        check({step, " w8df sum"},   s8d, e_s);
        check({step, " w8df carry"}, c8d, e_c);
        check({step, " w8cs sum"},   s8c, e_s);
        check({step, " w8cs carry"}, c8c, e_c);
    endtask

    task automatic check_regs(input string step, input logic e1s, input logic e1c,
                              input logic [7:0] e8s, input logic [7:0] e8c, input logic eov);
        check({step, " w1df sum_q"},     {7'b0, sq1d}, {7'b0, e1s});
        check({step, " w1df carry_q"},   {7'b0, cq1d}, {7'b0, e1c});
        check({step, " w1df out_valid"}, {7'b0, ov1d}, {7'b0, eov});
        check({step, " w1cs sum_q"},     {7'b0, sq1c}, {7'b0, e1s});
        check({step, " w1cs carry_q"},   {7'b0, cq1c}, {7'b0, e1c});
        check({step, " w1cs out_valid"}, {7'b0, ov1c}, {7'b0, eov});
        check({step, " w8df sum_q"},     sq8d, e8s);
        check({step, " w8df carry_q"},   cq8d, e8c);
        check({step, " w8df out_valid"}, {7'b0, ov8d}, {7'b0, eov});
        check({step, " w8cs sum_q"},     sq8c, e8s);
        check({step, " w8cs carry_q"},   cq8c, e8c);
        check({step, " w8cs out_valid"}, {7'b0, ov8c}, {7'b0, eov});
    endtask

    // Reference model: per-lane arithmetic sum, returned as {carry, sum}.
    function automatic logic [15:0] lane_add(input logic [7:0] x, input logic [7:0] y);
        logic [15:0] r;
        logic [1:0]  t;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            t        = {1'b0, x[i]} + {1'b0, y[i]};
            r[i]     = t[0];
            r[8 + i] = t[1];
        end
        return r;
    endfunction

    // Vector tables: {a, b, sum, carry} for WIDTH=1, {a, b, sum, carry} bytes for WIDTH=8.
    logic [3:0]  comb_tbl [9];
    logic [3:0]  b2b_tbl1 [4];
    logic [31:0] b2b_tbl8 [4];

    logic [7:0]  m1s, m1c, m8s, m8c;
    logic        mov;
    logic [15:0] r1, r8;
    logic [3:0]  v;
    logic [31:0] w;

    initial begin
        comb_tbl = '{4'b0000, 4'b0110, 4'b1010, 4'b1101, 4'b0110,
                     4'b1010, 4'b1101, 4'b0110, 4'b0000};
        b2b_tbl1 = '{4'b0110, 4'b1010, 4'b0000, 4'b1101};
        b2b_tbl8 = '{32'h0F0F000F, 32'hFF01FE01, 32'hAA55FF00, 32'h80800080};

        rst = 1'b1; in_valid = 1'b0;
        a1 = 1'b0; b1 = 1'b0; a8 = 8'h00; b8 = 8'h00;

        // Reset held for two edges.
        repeat (2) @(negedge clk);
        $display("step reset: registered outputs after 2 reset edges");
        check_regs("reset", 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

        // Exhaustive WIDTH=1 combinational sequence, reset still asserted.
        for (int i = 0; i < 9; i++) begin
            v  = comb_tbl[i];
            a1 = v[3];
            b1 = v[2];
            #10;
            $display("step comb1 %0d: a=%b b=%b", i, a1, b1);
            check_comb1("comb1", v[1], v[0]);
        end
        check_regs("comb-under-reset", 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

        // First registered result after reset release.
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b1;
        a1 = 1'b1; b1 = 1'b1; a8 = 8'hF0; b8 = 8'hCC;
        #1;
        $display("step comb8: a=%h b=%h", a8, b8);
        check_comb8("comb8", 8'h3C, 8'hC0);
        @(negedge clk);
        $display("step first-valid: registered 11 / F0+CC");
        check_regs("first-valid", 1'b0, 1'b1, 8'h3C, 8'hC0, 1'b1);

        // Hold: inputs toggle with in_valid low.
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a1 = ~a1; b1 = (i == 1); a8 = 8'h5A + 8'(i); b8 = 8'hA5 - 8'(i);
            @(negedge clk);
            $display("step hold %0d: a8=%h b8=%h in_valid=0", i, a8, b8);
            check_regs("hold", 1'b0, 1'b1, 8'h3C, 8'hC0, 1'b0);
        end

        // Back-to-back valid inputs, one result per cycle.
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            v = b2b_tbl1[i];
            w = b2b_tbl8[i];
            a1 = v[3]; b1 = v[2]; a8 = w[31:24]; b8 = w[23:16];
            @(negedge clk);
            $display("step b2b %0d: a8=%h b8=%h", i, a8, b8);
            check_regs("b2b", v[1], v[0], w[15:8], w[7:0], 1'b1);
        end

        // Reset on the same edge as a valid input: result discarded.
        rst = 1'b1; in_valid = 1'b1;
        a1 = 1'b1; b1 = 1'b0; a8 = 8'hFF; b8 = 8'h00;
        @(negedge clk);
        $display("step reset-mid-stream");
        check_regs("reset-mid", 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

        // Release with no valid input: still empty.
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        $display("step release-idle");
        check_regs("release-idle", 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

        // First valid after release appears one cycle later.
        in_valid = 1'b1; a1 = 1'b1; b1 = 1'b0; a8 = 8'h12; b8 = 8'h34;
        @(negedge clk);
        $display("step release-valid: a8=12 b8=34");
        check_regs("release-valid", 1'b1, 1'b0, 8'h26, 8'h10, 1'b1);

        // Random vectors with random qualification against the lane model.
        m1s = 8'h01; m1c = 8'h00; m8s = 8'h26; m8c = 8'h10; mov = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            a1 = 1'($urandom); b1 = 1'($urandom);
            a8 = 8'($urandom); b8 = 8'($urandom);
            in_valid = ($urandom_range(0, 3) != 0);
            r1 = lane_add({7'b0, a1}, {7'b0, b1});
            r8 = lane_add(a8, b8);
            #1;
            check_comb1("rand", r1[0], r1[8]);
            check_comb8("rand", r8[7:0], r8[15:8]);
            @(negedge clk);
            if (in_valid) begin
                m1s = {7'b0, r1[0]}; m1c = {7'b0, r1[8]};
                m8s = r8[7:0];       m8c = r8[15:8];
            end
            mov = in_valid;
            $display("rand %0d: a8=%h b8=%h v=%b", n, a8, b8, in_valid);
            check_regs("rand", m1s[0], m1c[0], m8s, m8c, mov);
        end

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
